// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller and instruction memory.
package imem_fetch_ctrl_pkg;

  localparam int unsigned DEPTH_DEF    = 32;
  localparam int unsigned IDX_W_DEF    = 5;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  // A fetch address is usable only when word aligned and inside the memory.
  function automatic logic pc_legal(input logic [31:0] pc, input int unsigned depth);
    return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_pc_next.sv
// Next-PC selection and legality check for the current fetch PC.
module imem_fetch_ctrl_pc_next
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic [31:0] pc,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        legal,
  output logic [31:0] pc_nxt
);

  // An illegal PC, a halt or a stall all freeze the PC so a faulting address stays visible.
  always_comb begin
    legal  = pc_legal(pc, DEPTH);
    pc_nxt = pc;
    if (legal && !halt_req && !stall)
      pc_nxt = br_taken ? br_target : pc + 32'd4;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: program loading, PC ownership and fetch gating.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load_Req,
  input  logic        Load_Valid,
  input  logic [31:0] Load_Data,
  input  logic        Load_Last,
  output logic        Load_Ready,
  output logic        Load_Done,
  input  logic        Start,
  input  logic        Halt_Req,
  input  logic        Stall,
  input  logic        Br_Taken,
  input  logic [31:0] Br_Target,
  output logic [31:0] Mem_Addr,
  output logic        Mem_WE,
  output logic [31:0] Mem_WData,
  input  logic [31:0] Mem_Inst,
  output logic [31:0] PC,
  output logic [31:0] Inst,
  output logic        Inst_Valid,
  output logic        Running,
  output logic        Fault,
  output logic [31:0] Inst_Count
);

  state_t           state_p0, state_nxt;
  logic [31:0]      pc_p0, cnt_p0, pc_adv;
  logic [IDX_W-1:0] ptr_p0;
  logic             fault_p0, done_p0;
  logic             legal, idle_or_halt, load_acc, load_end, run_ok;

  imem_fetch_ctrl_pc_next #(.DEPTH(DEPTH)) u_pc_next (
    .pc        (pc_p0),
    .halt_req  (Halt_Req),
    .stall     (Stall),
    .br_taken  (Br_Taken),
    .br_target (Br_Target),
    .legal     (legal),
    .pc_nxt    (pc_adv)
  );

  // Handshake qualifiers; a reset cycle never writes memory even mid-load.
  always_comb begin
    idle_or_halt = (state_p0 == S_IDLE) || (state_p0 == S_HALT);
    load_acc     = (state_p0 == S_LOAD) && Load_Valid && !Reset;
    load_end     = load_acc && (Load_Last || (ptr_p0 == IDX_W'(DEPTH - 1)));
    run_ok       = (state_p0 == S_RUN) && legal;
  end

  // Next-state logic; Load_Req has priority over Start when both arrive.
  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      S_IDLE, S_HALT: begin
        if (Load_Req)   state_nxt = S_LOAD;
        else if (Start) state_nxt = S_RUN;
      end
      S_LOAD: if (load_end) state_nxt = S_IDLE;
      S_RUN:  if (!legal || Halt_Req) state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: state, PC, load pointer, issue counter and sticky fault.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_p0 <= S_IDLE;
      pc_p0    <= RESET_PC;
      ptr_p0   <= '0;
      cnt_p0   <= '0;
      fault_p0 <= 1'b0;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      done_p0  <= load_end;
      if (idle_or_halt && Load_Req) begin
        ptr_p0   <= '0;
        fault_p0 <= 1'b0;
      end else if (idle_or_halt && Start) begin
        pc_p0    <= RESET_PC;
        cnt_p0   <= '0;
        fault_p0 <= 1'b0;
      end
      if (load_acc)
        ptr_p0 <= ptr_p0 + IDX_W'(1);
      if (state_p0 == S_RUN) begin
        pc_p0 <= pc_adv;
        if (!legal)
          fault_p0 <= 1'b1;
        else if (!Halt_Req && !Stall)
          cnt_p0 <= cnt_p0 + 32'd1;
      end
    end
  end

  // Memory port is owned by the loader in LOAD and by fetch otherwise.
  always_comb begin
    Load_Ready = (state_p0 == S_LOAD) && !Reset;
    Load_Done  = done_p0;
    Mem_WE     = load_acc;
    Mem_WData  = Load_Data;
    Mem_Addr   = (state_p0 == S_LOAD) ? {{(30 - IDX_W){1'b0}}, ptr_p0, 2'b00} : pc_p0;
    PC         = pc_p0;
    Inst       = run_ok ? Mem_Inst : NOP;
    Inst_Valid = run_ok;
    Running    = run_ok;
    Fault      = fault_p0;
    Inst_Count = cnt_p0;
  end

endmodule
